// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Constants and types shared by the arbiter writer endpoint.
//               ARB_DATA_W : byte width carried on the arbiter data path.
//               wr_state_t : writer FSM encoding (IDLE=0, REQ=1).
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int ARB_DATA_W = 8;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_REQ  = 1'b1
  } wr_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : writer_fifo
// Description : DEPTH x ARB_DATA_W buffer with power-of-2 wrapping pointers.
//               rd_data always shows the head entry. A push is ignored while
//               full and a pop is ignored while empty. There is no bypass
//               when full, even if a pop happens on the same edge.
// Ports       : clk      in   clock
//               rst      in   asynchronous active-high reset
//               push     in   write wr_data at the tail
//               pop      in   discard the head entry
//               wr_data  in   byte to write
//               rd_data  out  head byte
//               count    out  number of stored entries (0..DEPTH)
//               full     out  count == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module writer_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [ARB_DATA_W-1:0]   wr_data,
  output logic [ARB_DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ARB_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is reset so the head reads 8'h00 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : writer_fifo
`default_nettype wire

// File: rtl/arbiter_writer.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_writer
// Description : Requester-side endpoint of the arbiter req/busy protocol.
//               Buffers producer bytes and offers the head byte to one
//               arbiter port, holding o_req/o_data until accepted
//               (i_busy low on an edge with o_req high).
//               Optional macro ARB_WRITER_TIMEOUT_EN: the head byte is
//               dropped (o_drop pulse) after TIMEOUT consecutive stalled
//               cycles. Without the macro the writer waits indefinitely.
// Ports       : i_clk    in   clock
//               i_reset  in   asynchronous active-high reset
//               i_valid  in   producer byte available on i_data
//               i_data   in   producer byte
//               o_ready  out  buffer can accept (push = i_valid & o_ready)
//               o_req    out  head byte on o_data is offered to the arbiter
//               o_data   out  head-of-buffer byte
//               i_busy   in   arbiter did not accept, hold o_data
//               o_drop   out  one-cycle pulse: head byte discarded on timeout
//               o_level  out  buffered byte count including the one on o_data
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_writer
  import arb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [ARB_DATA_W-1:0]   i_data,
  output logic                    o_ready,
  output logic                    o_req,
  output logic [ARB_DATA_W-1:0]   o_data,
  input  logic                    i_busy,
  output logic                    o_drop,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("arbiter_writer: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arbiter_writer: TIMEOUT must be >= 1");
  end

  wr_state_t        state;
  wr_state_t        state_next;
  logic             push;
  logic             pop;
  logic             drop_hit;
  logic             fifo_full;
  logic [LVL_W-1:0] fifo_count;
  logic [LVL_W-1:0] count_after;

  writer_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (i_data),
    .rd_data (o_data),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  // push can only happen when not full, so this never exceeds DEPTH.
  assign count_after = fifo_count + LVL_W'(push) - LVL_W'(pop);
  assign o_ready     = ~fifo_full;
  assign o_level     = fifo_count;

`ifdef ARB_WRITER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] stall_cnt;

  // Counts consecutive stalled REQ cycles; any pop (transfer or drop) or
  // a non-stalled cycle restarts it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt <= '0;
    end else if (pop) begin
      stall_cnt <= '0;
    end else if ((state == WR_REQ) && i_busy) begin
      stall_cnt <= stall_cnt + TMR_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

  // The drop fires during the TIMEOUT-th stalled cycle itself.
  assign drop_hit = (state == WR_REQ) && i_busy && (stall_cnt == TMR_W'(TIMEOUT - 1));
`else
  assign drop_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= WR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WR_IDLE: begin
        if (push) state_next = WR_REQ;
      end
      WR_REQ: begin
        if (pop && (count_after == '0)) state_next = WR_IDLE;
      end
      default: state_next = WR_IDLE;
    endcase
  end

  // Outputs: o_req is the registered state, so a byte pushed in IDLE is
  // offered no earlier than the following cycle.
  always_comb begin
    o_req  = (state == WR_REQ);
    o_drop = drop_hit;
    push   = i_valid & ~fifo_full;
    pop    = (state == WR_REQ) & (~i_busy | drop_hit);
  end

endmodule : arbiter_writer
`default_nettype wire
